// File: rtl/banked_regfile.sv
// Banked register file: r0-r15 with mode-dependent banking of r8-r14,
// a PC with load/increment/exception redirect, CPSR and per-mode SPSRs.
module banked_regfile #(
    parameter int unsigned NUM_RD    = 3,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned PC_OFFSET = 8,
    parameter bit          BYPASS    = 1'b1
) (
    input  logic                     sysclk,
    input  logic                     nreset,
    input  logic [NUM_RD*4-1:0]      rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic [3:0]               wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        pc_wdata,
    input  logic                     pc_load,
    input  logic                     pc_inc,
    input  logic [31:0]              psr_wdata,
    input  logic                     psr_load,
    input  logic                     psr_w_sel,
    input  logic                     psr_r_sel,
    input  logic                     exc_req,
    input  logic [4:0]               exc_mode,
    input  logic [DATA_W-1:0]        exc_vector,
    output logic [DATA_W-1:0]        pc_rdata,
    output logic [31:0]              psr_rdata,
    output logic                     wr_dropped
);

    typedef enum logic [4:0] {
        MODE_USR = 5'b10000,
        MODE_FIQ = 5'b10001,
        MODE_IRQ = 5'b10010,
        MODE_SVC = 5'b10011
    } mode_e;

    // Banked copies of r13/r14 and SPSRs are indexed by mode[1:0]
    // (USR=0, FIQ=1, IRQ=2, SVC=3); SPSR entry 0 is never written.
    logic [DATA_W-1:0] rlo_q     [8];
    logic [DATA_W-1:0] rlo_d     [8];
    logic [DATA_W-1:0] rhi_usr_q [5];
    logic [DATA_W-1:0] rhi_usr_d [5];
    logic [DATA_W-1:0] rhi_fiq_q [5];
    logic [DATA_W-1:0] rhi_fiq_d [5];
    logic [DATA_W-1:0] r13_q     [4];
    logic [DATA_W-1:0] r13_d     [4];
    logic [DATA_W-1:0] r14_q     [4];
    logic [DATA_W-1:0] r14_d     [4];
    logic [31:0]       spsr_q    [4];
    logic [31:0]       spsr_d    [4];
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [3:0]        flags_q, flags_d;
    logic              i_q, i_d, f_q, f_d;
    mode_e             mode_q, mode_d;
    logic              wr_dropped_q, wr_dropped_d;

    logic [1:0]  bank;
    logic        in_fiq, priv, exc_ok, wr_commit, psr_mode_ok;
    logic [31:0] cpsr;
    logic        unused_psr_bits;

    assign bank        = mode_q[1:0];
    assign in_fiq      = (mode_q == MODE_FIQ);
    assign priv        = (mode_q != MODE_USR);
    assign cpsr        = {flags_q, 20'd0, i_q, f_q, 1'b0, mode_q};
    assign exc_ok      = exc_req && (exc_mode == MODE_FIQ || exc_mode == MODE_IRQ ||
                                     exc_mode == MODE_SVC);
    assign wr_commit   = wr_en && !exc_ok;
    assign psr_mode_ok = psr_wdata[4:0] inside {MODE_USR, MODE_FIQ, MODE_IRQ, MODE_SVC};
    assign unused_psr_bits = ^{psr_wdata[27:8], psr_wdata[5]};

    assign pc_rdata   = pc_q;
    assign psr_rdata  = (psr_r_sel && priv) ? spsr_q[bank] : cpsr;
    assign wr_dropped = wr_dropped_q;

    // Read ports: mode-mapped register, r15 as PC+offset, optional write forwarding
    always_comb begin
        logic [3:0]        ra;
        logic [DATA_W-1:0] val;
        rd_data = '0;
        ra      = '0;
        val     = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            ra = rd_addr[4*k +: 4];
            if (ra == 4'd15)
                val = pc_q + DATA_W'(PC_OFFSET);
            else if (ra < 4'd8)
                val = rlo_q[ra[2:0]];
            else if (ra < 4'd13)
                val = in_fiq ? rhi_fiq_q[ra[2:0]] : rhi_usr_q[ra[2:0]];
            else if (ra == 4'd13)
                val = r13_q[bank];
            else
                val = r14_q[bank];
            if (BYPASS && wr_commit && (wr_addr == ra) && (ra != 4'd15))
                val = wr_data;
            rd_data[DATA_W*k +: DATA_W] = val;
        end
    end

    // Next state: a valid exception overrides every other same-cycle update
    always_comb begin
        rlo_d        = rlo_q;
        rhi_usr_d    = rhi_usr_q;
        rhi_fiq_d    = rhi_fiq_q;
        r13_d        = r13_q;
        r14_d        = r14_q;
        spsr_d       = spsr_q;
        pc_d         = pc_q;
        flags_d      = flags_q;
        i_d          = i_q;
        f_d          = f_q;
        mode_d       = mode_q;
        wr_dropped_d = exc_ok && (wr_en || psr_load);

        if (exc_ok) begin
            spsr_d[exc_mode[1:0]] = cpsr;
            r14_d[exc_mode[1:0]]  = pc_q;
            mode_d                = mode_e'(exc_mode);
            i_d                   = 1'b1;
            if (exc_mode == MODE_FIQ)
                f_d = 1'b1;
            pc_d = exc_vector;
        end else begin
            if (wr_en) begin
                if (wr_addr == 4'd15)
                    pc_d = wr_data;
                else if (wr_addr < 4'd8)
                    rlo_d[wr_addr[2:0]] = wr_data;
                else if (wr_addr < 4'd13) begin
                    if (in_fiq)
                        rhi_fiq_d[wr_addr[2:0]] = wr_data;
                    else
                        rhi_usr_d[wr_addr[2:0]] = wr_data;
                end else if (wr_addr == 4'd13)
                    r13_d[bank] = wr_data;
                else
                    r14_d[bank] = wr_data;
            end
            if (!(wr_en && wr_addr == 4'd15)) begin
                if (pc_load)
                    pc_d = pc_wdata;
                else if (pc_inc)
                    pc_d = pc_q + DATA_W'(4);
            end
            if (psr_load) begin
                if (!psr_w_sel) begin
                    flags_d = psr_wdata[31:28];
                    if (priv) begin
                        i_d = psr_wdata[7];
                        f_d = psr_wdata[6];
                        if (psr_mode_ok)
                            mode_d = mode_e'(psr_wdata[4:0]);
                    end
                end else if (priv) begin
                    spsr_d[bank] = psr_wdata;
                end
            end
        end
    end

    // State registers with asynchronous active-low reset into SVC, IRQ/FIQ masked
    always_ff @(posedge sysclk or negedge nreset) begin
        if (!nreset) begin
            rlo_q        <= '{default: '0};
            rhi_usr_q    <= '{default: '0};
            rhi_fiq_q    <= '{default: '0};
            r13_q        <= '{default: '0};
            r14_q        <= '{default: '0};
            spsr_q       <= '{default: '0};
            pc_q         <= '0;
            flags_q      <= '0;
            i_q          <= 1'b1;
            f_q          <= 1'b1;
            mode_q       <= MODE_SVC;
            wr_dropped_q <= 1'b0;
        end else begin
            rlo_q        <= rlo_d;
            rhi_usr_q    <= rhi_usr_d;
            rhi_fiq_q    <= rhi_fiq_d;
            r13_q        <= r13_d;
            r14_q        <= r14_d;
            spsr_q       <= spsr_d;
            pc_q         <= pc_d;
            flags_q      <= flags_d;
            i_q          <= i_d;
            f_q          <= f_d;
            mode_q       <= mode_d;
            wr_dropped_q <= wr_dropped_d;
        end
    end

endmodule
